multi_digit_counter: RTL

MULTI_DIGIT_COUNTER -- requirements
Module: multi_digit_counter

---
 rtl/multi_digit_counter_pkg.sv | 15 +
 rtl/multi_digit_counter_if.sv | 29 ++
 rtl/multi_digit_counter_tick_gen.sv | 32 +++
 rtl/multi_digit_counter.sv | 112 +++++++++++
 4 files changed

// File: rtl/multi_digit_counter_pkg.sv
// Shared constants and helpers for the BCD multi-digit counter: digit width,
// largest legal digit value and the width calculation for rate dividers.
package multi_digit_counter_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] DIGIT_MAX = 4'd9;

  // Bits needed for a divider counter running 0..(clk_hz/rate_hz)-1.
  function automatic int div_width(input int clk_hz, input int rate_hz);
    int div;
    div = clk_hz / rate_hz;
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/multi_digit_counter_if.sv
// Control and display bundle of the counter; the counter core is the slave,
// whoever drives the controls and watches the display is the master.
interface multi_digit_counter_if
  import multi_digit_counter_pkg::*;
#(
  parameter int DIGITS = 2
);

  logic                      en;
  logic                      up;
  logic                      load;
  logic [BCD_W*DIGITS-1:0]   load_val;
  logic [BCD_W*DIGITS-1:0]   bcd;
  logic                      tick;
  logic                      tc;
  logic [DIGITS-1:0]         an;
  logic [BCD_W-1:0]          digit;

  modport master (
    output en, up, load, load_val,
    input  bcd, tick, tc, an, digit
  );

  modport slave (
    input  en, up, load, load_val,
    output bcd, tick, tc, an, digit
  );

endinterface

// File: rtl/multi_digit_counter_tick_gen.sv
// Rate divider: counts 0..DIV-1 and flags the cycle spent at DIV-1, giving a
// one-cycle enable pulse every DIV clocks without deriving a new clock.
module tick_gen
  import multi_digit_counter_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = div_width(DIV, 1);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) cnt_d = '0;
  end

  // NOTE: state is updated with non-blocking assignments only, so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/multi_digit_counter.sv
// Multi-digit BCD up/down counter with load, terminal-count pulse and a
// multiplexed active-low display scan, all paced by enables on one clock.
module multi_digit_counter
  import multi_digit_counter_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int SCAN_HZ = 1000,
  parameter int DIGITS  = 2
) (
  input logic                  clk,
  input logic                  rst,
  multi_digit_counter_if.slave bus
);

  localparam int W     = BCD_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic             count_tick;
  logic             scan_tick;
  logic [W-1:0]     bcd_q, bcd_d;
  logic [W-1:0]     load_clamped;
  logic [W-1:0]     step_val;
  logic             wrap;
  logic [BCD_W-1:0] cur;
  logic             tc_q, tc_d;
  logic [IDX_W-1:0] scan_idx_q, scan_idx_d;

  tick_gen #(.DIV(CLK_HZ / TICK_HZ)) u_count_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (count_tick)
  );

  tick_gen #(.DIV(CLK_HZ / SCAN_HZ)) u_scan_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (scan_tick)
  );

  always_comb begin
    load_clamped = bus.load_val;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.load_val[i*BCD_W +: BCD_W] > DIGIT_MAX)
        load_clamped[i*BCD_W +: BCD_W] = DIGIT_MAX;
    end
  end

  // Ripple carry/borrow: wrap stays set only while every lower digit rolled over.
  always_comb begin
    step_val = bcd_q;
    wrap     = 1'b1;
    cur      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      cur = bcd_q[i*BCD_W +: BCD_W];
      if (wrap) begin
        if (bus.up) begin
          if (cur == DIGIT_MAX) begin
            step_val[i*BCD_W +: BCD_W] = '0;
          end else begin
            step_val[i*BCD_W +: BCD_W] = cur + 1'b1;
            wrap = 1'b0;
          end
        end else begin
          if (cur == '0) begin
            step_val[i*BCD_W +: BCD_W] = DIGIT_MAX;
          end else begin
            step_val[i*BCD_W +: BCD_W] = cur - 1'b1;
            wrap = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    bcd_d = bcd_q;
    tc_d  = 1'b0;
    if (bus.load) begin
      bcd_d = load_clamped;
    end else if (count_tick && bus.en) begin
      bcd_d = step_val;
      tc_d  = wrap;
    end
  end

  always_comb begin
    scan_idx_d = scan_idx_q;
    if (DIGITS > 1 && scan_tick)
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bcd_q      <= '0;
      tc_q       <= 1'b0;
      scan_idx_q <= '0;
    end else begin
      bcd_q      <= bcd_d;
      tc_q       <= tc_d;
      scan_idx_q <= scan_idx_d;
    end
  end

  assign bus.bcd   = bcd_q;
  assign bus.tc    = tc_q;
  assign bus.tick  = count_tick;
  assign bus.an    = ~(DIGITS'(1) << scan_idx_q);
  assign bus.digit = bcd_q[scan_idx_q*BCD_W +: BCD_W];

endmodule
